// File: rtl/xip_pkg.sv
// xip_pkg: shared state type, address width and line alignment helper for the XIP line-fill arbiter
package xip_pkg;

    localparam int XIP_ADDR_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        ACK,
        PF_ISSUE
    } fill_state_t;

    function automatic logic [XIP_ADDR_W-1:0] line_align(input logic [XIP_ADDR_W-1:0] addr, input int off_w);
        logic [XIP_ADDR_W-1:0] mask;
        mask = '1;
        return addr & (mask << off_w);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; rr_last remembers the last winner (1 = M1)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic rr_last;

    // on a tie the requester that did not win last time is granted
    always_comb gnt = (&req) ? (rr_last ? 2'b01 : 2'b10) : req;

    // remember the winner whenever a grant is taken; reset favours M0 on the first tie
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            rr_last <= 1'b1;
        else if (update && |req)
            rr_last <= gnt[1];

endmodule

// File: rtl/xip_line_fill_arbiter.sv
// xip_line_fill_arbiter: shares one flash line reader between two cache-miss requesters; optional next-line prefetch under XIP_NEXT_LINE_PREFETCH_EN
module xip_line_fill_arbiter
    import xip_pkg::*;
#(
    parameter int LINE_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic [XIP_ADDR_W-1:0] m0_addr,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic [XIP_ADDR_W-1:0] m1_addr,
    output logic                  m1_ack,
    output logic                  fl_rd,
    output logic [XIP_ADDR_W-1:0] fl_addr,
    input  logic                  fl_done,
    output logic                  cache_wr,
    output logic [XIP_ADDR_W-1:0] cache_a,
    output logic                  busy
);

    localparam int OFF_W = $clog2(LINE_SIZE);

    fill_state_t           state;
    logic                  gsel;
    logic [1:0]            gnt;
    logic [XIP_ADDR_W-1:0] m0_line;
    logic [XIP_ADDR_W-1:0] m1_line;
    logic                  m0_hit;
    logic                  m1_hit;
`ifdef XIP_NEXT_LINE_PREFETCH_EN
    logic                  pf;
    logic                  pending;
`endif

    assign m0_line = line_align(m0_addr, OFF_W);
    assign m1_line = line_align(m1_addr, OFF_W);
    assign m0_hit  = m0_req && (m0_line == fl_addr);
    assign m1_hit  = m1_req && (m1_line == fl_addr);
    assign busy    = state != IDLE;
    assign cache_a = fl_addr;
`ifdef XIP_NEXT_LINE_PREFETCH_EN
    assign pending = (m0_req && !m0_ack) || (m1_req && !m1_ack);
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({m1_req, m0_req}),
        .update (state == IDLE),
        .gnt    (gnt)
    );

    // fill sequencer: grant, issue one read once the reader's done has drained, write the line, ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gsel     <= 1'b0;
            fl_rd    <= 1'b0;
            fl_addr  <= '0;
            cache_wr <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
`ifdef XIP_NEXT_LINE_PREFETCH_EN
            pf       <= 1'b0;
`endif
        end else begin
            fl_rd    <= 1'b0;
            cache_wr <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            case (state)
                IDLE: if (|gnt) begin
                    gsel    <= gnt[1];
                    fl_addr <= gnt[1] ? m1_line : m0_line;
                    fl_rd   <= !fl_done;
                    state   <= ISSUE;
                end
                ISSUE, PF_ISSUE: begin
                    if (fl_rd)
                        state <= WAIT;
                    else
                        fl_rd <= !fl_done;
                end
                WAIT: if (fl_done) begin
                    cache_wr <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
`ifdef XIP_NEXT_LINE_PREFETCH_EN
                    if (pf) begin
                        m0_ack <= m0_hit;
                        m1_ack <= m1_hit;
                        state  <= (m0_hit || m1_hit) ? ACK : IDLE;
                        pf     <= m0_hit || m1_hit;
                    end else
`endif
                    begin
                        m0_ack <= !gsel || m0_hit;
                        m1_ack <= gsel || m1_hit;
                        state  <= ACK;
                    end
                end
                ACK: begin
`ifdef XIP_NEXT_LINE_PREFETCH_EN
                    if (!pf && !pending) begin
                        pf      <= 1'b1;
                        fl_addr <= fl_addr + XIP_ADDR_W'(LINE_SIZE);
                        fl_rd   <= !fl_done;
                        state   <= PF_ISSUE;
                    end else begin
                        pf    <= 1'b0;
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xip_line_fill_arbiter.sv
// tb_xip_line_fill_arbiter: directed and randomized checks of the line-fill arbiter against a transaction-level model
module tb_xip_line_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0;
    logic        m1_req = 1'b0;
    logic [23:0] m0_addr = '0;
    logic [23:0] m1_addr = '0;
    logic        m0_ack, m1_ack, fl_rd, fl_done, cache_wr, busy;
    logic [23:0] fl_addr, cache_a;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xip_line_fill_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_ack   (m0_ack),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_ack   (m1_ack),
        .fl_rd    (fl_rd),
        .fl_addr  (fl_addr),
        .fl_done  (fl_done),
        .cache_wr (cache_wr),
        .cache_a  (cache_a),
        .busy     (busy)
    );

    // flash line reader: done rises rd_lat cycles after a read and stays up done_hold cycles
    int rd_lat = 40;
    int done_hold = 1;
    int rcnt = 0;
    int hcnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_done <= 1'b0;
            rcnt    <= 0;
            hcnt    <= 0;
        end else if (fl_rd) begin
            rcnt <= rd_lat;
        end else if (rcnt > 1) begin
            rcnt <= rcnt - 1;
        end else if (rcnt == 1) begin
            rcnt    <= 0;
            fl_done <= 1'b1;
            hcnt    <= done_hold;
        end else if (hcnt > 1) begin
            hcnt <= hcnt - 1;
        end else if (hcnt == 1) begin
            hcnt    <= 0;
            fl_done <= 1'b0;
        end
    end

    // event monitor: counts and timestamps of reads, writes and acks
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_rd = 0, n_wr = 0, n_a0 = 0, n_a1 = 0;
    int t_rd = 0, t_wr = 0, t_done = 0, bad_rd = 0;
    logic prev_done = 1'b0;
    logic [23:0] rd_q[$];
    logic [23:0] wr_q[$];
    int lat_q[$];
    always @(negedge clk) begin
        if (fl_rd) begin
            n_rd++;
            t_rd = cyc;
            rd_q.push_back(fl_addr);
            if (prev_done) bad_rd++;
        end
        if (fl_done && !prev_done) t_done = cyc;
        if (cache_wr) begin
            n_wr++;
            t_wr = cyc;
            wr_q.push_back(cache_a);
            lat_q.push_back(cyc - t_done);
        end
        if (m0_ack || m1_ack) lat_q.push_back(cyc - t_wr);
        if (m0_ack) n_a0++;
        if (m1_ack) n_a1++;
        prev_done = fl_done;
    end

    int b_rd, b_wr, b_a0, b_a1, t_req;
    bit m_last = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rd = n_rd;
        b_wr = n_wr;
        b_a0 = n_a0;
        b_a1 = n_a1;
    endtask

    task automatic chk_lat(input string tag);
        while (lat_q.size() != 0) chk({tag, "_latency"}, lat_q.pop_front(), 1);
    endtask

    task automatic chk_line(input string tag, input logic [23:0] exp);
        logic [23:0] v;
        v = 'x;
        if (rd_q.size() != 0) v = rd_q.pop_front();
        chk({tag, "_fl_addr"}, v, exp);
        v = 'x;
        if (wr_q.size() != 0) v = wr_q.pop_front();
        chk({tag, "_cache_a"}, v, exp);
    endtask

    task automatic settle(input string tag, input int budget, output int ta0, output int ta1);
        int n;
        n = 0;
        ta0 = -1;
        ta1 = -1;
        while ((m0_req || m1_req || busy) && n < budget) begin
            @(negedge clk);
            n++;
            if (m0_ack) begin m0_req = 1'b0; ta0 = cyc; end
            if (m1_ack) begin m1_req = 1'b0; ta1 = cyc; end
        end
        chk({tag, "_settled"}, 32'(n < budget), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = 1'b1;
        @(negedge clk);
    endtask

    // one demand transaction: raise the selected requests together, run to completion, compare with the model
    task automatic txn(input string tag, input int sel, input logic [23:0] a0, input logic [23:0] a1,
                       input int lat, input int hold);
        int ta0, ta1, first;
        logic [23:0] l0, l1;
        logic [23:0] exp_q[$];
        snap();
        rd_lat = lat;
        done_hold = hold;
        m0_addr = a0;
        m1_addr = a1;
        m0_req = (sel & 1) != 0;
        m1_req = (sel & 2) != 0;
        t_req = cyc;
        settle(tag, 2000, ta0, ta1);
        l0 = a0 & 24'hFFFFF0;
        l1 = a1 & 24'hFFFFF0;
        if (sel == 1) begin
            exp_q.push_back(l0);
            chk({tag, "_m1_acks"}, n_a1 - b_a1, 0);
            m_last = 1'b0;
        end else if (sel == 2) begin
            exp_q.push_back(l1);
            chk({tag, "_m0_acks"}, n_a0 - b_a0, 0);
            m_last = 1'b1;
        end else begin
            first = m_last ? 0 : 1;
            if (l0 == l1) begin
                exp_q.push_back(l0);
                chk({tag, "_coalesced_same_cycle"}, 32'(ta0 == ta1), 1);
                m_last = first[0];
            end else begin
                exp_q.push_back(first == 0 ? l0 : l1);
                exp_q.push_back(first == 0 ? l1 : l0);
                chk({tag, "_m0_first"}, 32'(ta0 < ta1), 32'(first == 0));
                m_last = !first[0];
            end
            chk({tag, "_m0_acks"}, n_a0 - b_a0, 1);
            chk({tag, "_m1_acks"}, n_a1 - b_a1, 1);
        end
        chk({tag, "_reads"}, n_rd - b_rd, exp_q.size());
        chk({tag, "_writes"}, n_wr - b_wr, exp_q.size());
        foreach (exp_q[k]) chk_line(tag, exp_q[k]);
        chk_lat(tag);
    endtask

    initial begin
        int ta0, ta1, n, sel;
        logic [23:0] a0, a1;
        repeat (3) @(negedge clk);
        chk("rst_fl_rd", fl_rd, 0);
        chk("rst_cache_wr", cache_wr, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_fl_addr", fl_addr, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef XIP_NEXT_LINE_PREFETCH_EN
        snap();
        rd_lat = 20;
        done_hold = 1;
        m0_addr = 24'hFFFFF8;
        m0_req = 1'b1;
        n = 0;
        while (n_rd - b_rd < 2 && n < 300) begin
            @(negedge clk);
            n++;
            if (m0_ack) m0_req = 1'b0;
        end
        chk("pf_started", 32'(n < 300), 1);
        chk("pf_m0_acks", n_a0 - b_a0, 1);
        m1_addr = 24'h000004;
        m1_req = 1'b1;
        settle("pf", 300, ta0, ta1);
        chk("pf_m1_acked", 32'(ta1 >= 0), 1);
        chk_line("pf_demand", 24'hFFFFF0);
        chk_line("pf_next", 24'h000000);
        chk("pf_m0_acks_total", n_a0 - b_a0, 1);
        chk("pf_m1_acks_total", n_a1 - b_a1, 1);
        chk_lat("pf");
        repeat (60) @(negedge clk);
        chk("pf_reads", n_rd - b_rd, 2);
        chk("pf_writes", n_wr - b_wr, 2);
        chk("pf_idle", busy, 0);
`else
        txn("single", 1, 24'h001234, 24'h000000, 40, 1);
        chk("single_rd_latency", t_rd - t_req, 1);
        do_reset();
        txn("tie_a", 3, 24'h000100, 24'h002200, 6, 1);
        txn("solo", 1, 24'h000340, 24'h000000, 4, 1);
        txn("tie_b", 3, 24'h000500, 24'h003600, 5, 1);
        txn("coal", 3, 24'h000104, 24'h00010C, 5, 1);
        txn("hold", 3, 24'h000700, 24'h000800, 3, 6);
        chk("hold_no_rd_while_done", bad_rd, 0);
        snap();
        rd_lat = 30;
        done_hold = 1;
        m0_addr = 24'h00ABCD;
        m0_req = 1'b1;
        n = 0;
        while (n_rd == b_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rw_rd_seen", 32'(n < 100), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        m0_req = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_fl_addr", fl_addr, 0);
        @(negedge clk);
        chk("rw_fl_rd", fl_rd, 0);
        chk("rw_cache_wr", cache_wr, 0);
        chk("rw_acks", {m1_ack, m0_ack}, 0);
        rst_n = 1'b1;
        m_last = 1'b1;
        repeat (60) @(negedge clk);
        chk("rw_no_write", n_wr - b_wr, 0);
        chk("rw_no_ack", (n_a0 - b_a0) + (n_a1 - b_a1), 0);
        chk("rw_idle", busy, 0);
        chk("rw_reads", n_rd - b_rd, 1);
        if (rd_q.size() != 0) chk("rw_fl_addr_issued", rd_q.pop_front(), 24'h00ABC0);
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(1, 3);
            a0 = 24'($urandom);
            a1 = ($urandom_range(0, 2) == 0) ? {a0[23:4], 4'($urandom)} : 24'($urandom);
            txn($sformatf("rnd%0d", i), sel, a0, a1, $urandom_range(1, 8), $urandom_range(1, 4));
        end
        chk("end_no_rd_while_done", bad_rd, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
